board_loader: RTL and testbench

//   Writer into the double buffer's logic write port. Fills the back buffer with an initial board

---
 rtl/board_loader_pkg.sv | 32 +++
 rtl/board_loader.sv | 153 +++++++++++++++
 tb/tb_board_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_loader_pkg.sv
// board_loader_pkg
//   Shared types and constants for the board loader and its neighbours on the
//   double buffer's logic write port (life_logic, renderer).
//   - BOARD_WORDS_C : data_t words per 128x128 board (16 cells per word)
//   - WORD_BITS_C   : cells per data_t word
//   - BYTES_PER_W_C : stream bytes packed into one data_t word
//   - addr_t / data_t / pos_t : word address, word data, cell row/column
//   - loader_state_t : loader FSM encoding; the CLEAR state exists only when
//     the LOADER_CLEAR_EN macro is defined.
package board_loader_pkg;

    localparam int BOARD_WORDS_C = 1024;
    localparam int WORD_BITS_C   = 16;
    localparam int BYTES_PER_W_C = 2;
    localparam int ADDR_W_C      = $clog2(BOARD_WORDS_C);

    typedef logic [ADDR_W_C-1:0]    addr_t;
    typedef logic [WORD_BITS_C-1:0] data_t;
    typedef logic [6:0]             pos_t;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
`ifdef LOADER_CLEAR_EN
        ,
        CLEAR
`endif
    } loader_state_t;

endpackage

// File: rtl/board_loader.sv
// board_loader
//   Fills the back buffer with an initial board received as a valid/ready byte
//   stream. Bytes are packed little-endian into data_t words (byte 0 -> bits
//   [7:0]) and each completed word is written with a single wr_en_out cycle.
//   Optional feature macro: LOADER_CLEAR_EN adds clear_in and a CLEAR state
//   that zero-fills the whole board.
// Ports
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   clear_in            : (LOADER_CLEAR_EN only) 1-cycle pulse, zero-fill board
//   start_in            : 1-cycle pulse, begin a load from word 0
//   in_valid/in_data    : stream byte and its valid
//   in_ready            : high while the loader can accept a byte
//   addr_w_out/data_w_out/wr_en_out : double buffer logic write port
//   busy_out            : load/clear in progress
//   done_out            : 1-cycle pulse after the last word is written
module board_loader
    import board_loader_pkg::*;
#(
    parameter int BOARD_WORDS = BOARD_WORDS_C,
    parameter int BYTES_PER_W = BYTES_PER_W_C
) (
    input  logic       clk_in,
    input  logic       rst_in,
`ifdef LOADER_CLEAR_EN
    input  logic       clear_in,
`endif
    input  logic       start_in,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output addr_t      addr_w_out,
    output data_t      data_w_out,
    output logic       wr_en_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam int CNT_W = (BYTES_PER_W > 1) ? $clog2(BYTES_PER_W) : 1;
    localparam addr_t           LAST_ADDR = addr_t'(BOARD_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_W - 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    addr_t            addr_q, addr_d;
    data_t            data_q, data_d;
    logic             in_ready_q, in_ready_d;
    logic             wr_en_q, wr_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d    = RECV;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                end
`ifdef LOADER_CLEAR_EN
                else if (clear_in) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    data_d  = '0;
                end
`endif
            end
            RECV: begin
                // in_ready_q is exactly (state_q == RECV); using it keeps the
                // accept condition identical to what the source sees.
                if (in_valid && in_ready_q) begin
                    data_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    if (byte_cnt_q == LAST_LANE) begin
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // The address saturates at the last word: no wrap, no extra write.
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RECV;
                end
            end
`ifdef LOADER_CLEAR_EN
            CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
`endif
            DONE: begin
                // start_in is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        in_ready_d = (state_d == RECV);
        done_d     = (state_d == DONE);
`ifdef LOADER_CLEAR_EN
        wr_en_d    = (state_d == WRITE) || (state_d == CLEAR);
        busy_d     = (state_d == RECV) || (state_d == WRITE) || (state_d == CLEAR);
`else
        wr_en_d    = (state_d == WRITE);
        busy_d     = (state_d == RECV) || (state_d == WRITE);
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign addr_w_out = addr_q;
    assign data_w_out = data_q;
    assign wr_en_out  = wr_en_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader
//   Scoreboard bench for board_loader. The stream driver pushes the expected
//   {addr, data} of every word into exp_q as its last byte is handed over and
//   records every DUT write into act_q; each test task then compares them.
//   Define LOADER_CLEAR_EN to also exercise the clear feature.
module tb_board_loader;
    import board_loader_pkg::*;

    localparam int BUDGET    = 8000;
    localparam int LOAD_CYC  = 3 * BOARD_WORDS_C;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
`ifdef LOADER_CLEAR_EN
    logic       clear_in = 1'b0;
`endif
    logic       start_in = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    addr_t      addr_w_out;
    data_t      data_w_out;
    logic       wr_en_out;
    logic       busy_out;
    logic       done_out;

    board_loader dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
`ifdef LOADER_CLEAR_EN
        .clear_in   (clear_in),
`endif
        .start_in   (start_in),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .addr_w_out (addr_w_out),
        .data_w_out (data_w_out),
        .wr_en_out  (wr_en_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef logic [$bits(addr_t)+$bits(data_t)-1:0] wr_t;

    wr_t        exp_q[$];
    wr_t        act_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc, n_done, done_cyc, busy_err, rdy_err;
    logic [7:0] rdy_hist;
    bit         timed_out, aborted;

    function automatic logic [7:0] byte_of(input int i);
        if (i == 0) return 8'h34;
        if (i == 1) return 8'h12;
        return 8'((i * 37) ^ (i >> 3));
    endfunction

    // Stream driver: pulses start_in, feeds bytes (optionally with gaps),
    // optionally pulses start_in again or asserts rst_in at a byte index.
    task automatic drive_load(input int gap_pct, input int restart_idx, input int rst_idx);
        int idx;
        bit restarted;
        idx = 0; restarted = 0;
        cyc = 0; n_done = 0; done_cyc = -1; busy_err = 0; rdy_err = 0;
        rdy_hist = '0; timed_out = 0; aborted = 0;
        exp_q.delete(); act_q.delete();
        @(negedge clk_in);
        start_in = 1'b1;
        in_valid = 1'b0;
        forever begin
            @(negedge clk_in);
            start_in = 1'b0;
            in_valid = 1'b0;
            if (wr_en_out) begin
                act_q.push_back({addr_w_out, data_w_out});
                if (in_ready) rdy_err++;
            end
            if (cyc < 8) rdy_hist[cyc] = in_ready;
            if (done_out) begin
                n_done++;
                done_cyc = cyc;
                if (busy_out) busy_err++;
                break;
            end else if (!busy_out) begin
                busy_err++;
            end
            if (cyc >= BUDGET) begin
                timed_out = 1;
                break;
            end
            if (rst_idx >= 0 && idx == rst_idx && in_ready) begin
                rst_in  = 1'b1;
                aborted = 1;
                break;
            end
            if (restart_idx >= 0 && idx == restart_idx && !restarted) begin
                start_in  = 1'b1;
                restarted = 1;
            end
            if ($urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = byte_of(idx);
                if (in_ready) begin
                    if (idx % 2 == 1)
                        exp_q.push_back({addr_t'(idx / 2), byte_of(idx), byte_of(idx - 1)});
                    idx++;
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        int rdy_hi, wr_hi;
        rst_in = 1'b0;
        #1 rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_cmp++; if (in_ready   !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (wr_en_out  !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en_out); end
        n_cmp++; if (busy_out   !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
        n_cmp++; if (done_out   !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done_out); end
        n_cmp++; if (addr_w_out !== '0)   begin n_bad++; $display("FAIL reset_addr got=%h want=0", addr_w_out); end
        n_cmp++; if (data_w_out !== '0)   begin n_bad++; $display("FAIL reset_data got=%h want=0", data_w_out); end
        rst_in = 1'b0;
        // in_valid while idle must be ignored.
        rdy_hi = 0; wr_hi = 0;
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (6) begin
            @(negedge clk_in);
            if (in_ready)  rdy_hi++;
            if (wr_en_out) wr_hi++;
        end
        in_valid = 1'b0;
        n_cmp++; if (rdy_hi + wr_hi !== 0) begin n_bad++; $display("FAIL idle_valid_ignored got=%0d want=0", rdy_hi + wr_hi); end
    endtask

    task automatic test_full_load();
        wr_t e, a;
        int extra;
        drive_load(0, -1, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL full_timeout got=%b want=0", timed_out); end
        n_cmp++; if (act_q.size() !== BOARD_WORDS_C) begin n_bad++; $display("FAIL full_write_count got=%0d want=%0d", act_q.size(), BOARD_WORDS_C); end
        if (act_q.size() > 0) begin
            n_cmp++; if (act_q[0] !== {addr_t'(0), 16'h1234}) begin n_bad++; $display("FAIL first_word got=%h want=%h", act_q[0], {addr_t'(0), 16'h1234}); end
        end
        n_cmp++; if (rdy_hist !== 8'b1101_1011) begin n_bad++; $display("FAIL ready_gap got=%b want=11011011", rdy_hist); end
        n_cmp++; if (done_cyc !== LOAD_CYC) begin n_bad++; $display("FAIL done_cycle got=%0d want=%0d", done_cyc, LOAD_CYC); end
        n_cmp++; if (busy_err !== 0) begin n_bad++; $display("FAIL full_busy got=%0d want=0", busy_err); end
        n_cmp++; if (rdy_err !== 0) begin n_bad++; $display("FAIL full_ready_in_write got=%0d want=0", rdy_err); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL full_word got=%h want=%h", a, e); end
        end
        extra = 0;
        in_valid = 1'b1;
        repeat (8) begin
            @(negedge clk_in);
            if (wr_en_out || done_out || busy_out) extra++;
        end
        in_valid = 1'b0;
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL after_done_quiet got=%0d want=0", extra); end
    endtask

    task automatic test_gaps();
        wr_t e, a;
        drive_load(30, -1, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL gaps_timeout got=%b want=0", timed_out); end
        n_cmp++; if (act_q.size() !== BOARD_WORDS_C) begin n_bad++; $display("FAIL gaps_write_count got=%0d want=%0d", act_q.size(), BOARD_WORDS_C); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL gaps_done got=%0d want=1", n_done); end
        n_cmp++; if (busy_err !== 0) begin n_bad++; $display("FAIL gaps_busy got=%0d want=0", busy_err); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL gaps_word got=%h want=%h", a, e); end
        end
    endtask

    task automatic test_restart_ignored();
        wr_t e, a;
        drive_load(0, 1000, -1);
        n_cmp++; if (act_q.size() !== BOARD_WORDS_C) begin n_bad++; $display("FAIL restart_write_count got=%0d want=%0d", act_q.size(), BOARD_WORDS_C); end
        n_cmp++; if (done_cyc !== LOAD_CYC) begin n_bad++; $display("FAIL restart_done_cycle got=%0d want=%0d", done_cyc, LOAD_CYC); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL restart_word got=%h want=%h", a, e); end
        end
    endtask

    task automatic test_reset_mid_load();
        wr_t e, a;
        int stray;
        drive_load(0, -1, 400);
        #1;
        n_cmp++; if (aborted !== 1'b1) begin n_bad++; $display("FAIL midrst_reached got=%b want=1", aborted); end
        n_cmp++; if ({in_ready, wr_en_out, busy_out, done_out, addr_w_out, data_w_out} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs got=%h want=0", {in_ready, wr_en_out, busy_out, done_out, addr_w_out, data_w_out});
        end
        n_cmp++; if (act_q.size() !== 200) begin n_bad++; $display("FAIL midrst_partial_count got=%0d want=200", act_q.size()); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL midrst_partial_word got=%h want=%h", a, e); end
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        stray = 0;
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (10) begin
            @(negedge clk_in);
            if (wr_en_out || in_ready || busy_out) stray++;
        end
        in_valid = 1'b0;
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL midrst_quiet got=%0d want=0", stray); end
        drive_load(0, -1, -1);
        n_cmp++; if (act_q.size() !== BOARD_WORDS_C) begin n_bad++; $display("FAIL reload_write_count got=%0d want=%0d", act_q.size(), BOARD_WORDS_C); end
        if (act_q.size() > 0) begin
            n_cmp++; if (act_q[0][$bits(wr_t)-1 -: $bits(addr_t)] !== addr_t'(0)) begin n_bad++; $display("FAIL reload_first_addr got=%h want=0", act_q[0][$bits(wr_t)-1 -: $bits(addr_t)]); end
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL reload_word got=%h want=%h", a, e); end
        end
    endtask

`ifdef LOADER_CLEAR_EN
    task automatic test_clear();
        wr_t e, a;
        int n, rdy_hi, dn;
        bit to;
        exp_q.delete(); act_q.delete();
        for (int w = 0; w < BOARD_WORDS_C; w++) exp_q.push_back({addr_t'(w), data_t'(0)});
        n = 0; rdy_hi = 0; dn = 0; to = 0;
        @(negedge clk_in);
        clear_in = 1'b1;
        forever begin
            @(negedge clk_in);
            clear_in = 1'b0;
            if (wr_en_out) act_q.push_back({addr_w_out, data_w_out});
            if (in_ready) rdy_hi++;
            if (done_out) begin dn++; break; end
            if (n >= BUDGET) begin to = 1; break; end
            n++;
        end
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL clear_timeout got=%b want=0", to); end
        n_cmp++; if (n !== BOARD_WORDS_C) begin n_bad++; $display("FAIL clear_done_cycle got=%0d want=%0d", n, BOARD_WORDS_C); end
        n_cmp++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL clear_ready got=%0d want=0", rdy_hi); end
        n_cmp++; if (act_q.size() !== BOARD_WORDS_C) begin n_bad++; $display("FAIL clear_write_count got=%0d want=%0d", act_q.size(), BOARD_WORDS_C); end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL clear_word got=%h want=%h", a, e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_restart_ignored();
        test_reset_mid_load();
`ifdef LOADER_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
